// File: rtl/opstack_scheduler.sv
// Operator-stack (shunting-yard) scheduler for the calculator CPU: takes infix
// operator tokens and issues reduce commands to the evaluator in evaluation order.

package opstack_pkg;
    localparam int CO_AD = 1;
    localparam int CO_SB = 2;
    localparam int CO_MU = 3;
    localparam int CO_DI = 4;
    localparam int CO_PS = 5;
    localparam int CO_NS = 6;
    localparam int CO_LP = 7;
    localparam int CO_RP = 8;
    localparam int CO_OK = 9;
endpackage

// Precedence comparator: lle_rlt=1 means the stack top (b) must be reduced
// before the incoming operator (a) can be pushed.
module precedence
    import opstack_pkg::*;
#(
    parameter int CO_N = 4
) (
    input  logic [CO_N-1:0] a,
    input  logic [CO_N-1:0] b,
    output logic            lle_rlt
);
    function automatic logic [1:0] rank(input logic [CO_N-1:0] op);
        if (op == CO_N'(CO_PS) || op == CO_N'(CO_NS)) return 2'd3;
        if (op == CO_N'(CO_MU) || op == CO_N'(CO_DI)) return 2'd2;
        if (op == CO_N'(CO_AD) || op == CO_N'(CO_SB)) return 2'd1;
        return 2'd0;
    endfunction

    logic right_assoc;

    // Prefix operators are right-associative: only a strictly tighter top reduces.
    assign right_assoc = rank(a) == 2'd3;
    assign lle_rlt     = right_assoc ? (rank(a) < rank(b)) : (rank(a) <= rank(b));
endmodule

module opstack_scheduler
    import opstack_pkg::*;
#(
    parameter int CO_N  = 4,
    parameter int DEPTH = 8,
    parameter int DW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            tok_valid,
    input  logic [CO_N-1:0] tok_op,
    output logic            tok_ready,
    output logic            ev_valid,
    output logic [CO_N-1:0] ev_op,
    input  logic            ev_ready,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [DW-1:0]   depth
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CO_N-1:0] OP_AD = CO_N'(CO_AD);
    localparam logic [CO_N-1:0] OP_SB = CO_N'(CO_SB);
    localparam logic [CO_N-1:0] OP_MU = CO_N'(CO_MU);
    localparam logic [CO_N-1:0] OP_DI = CO_N'(CO_DI);
    localparam logic [CO_N-1:0] OP_PS = CO_N'(CO_PS);
    localparam logic [CO_N-1:0] OP_NS = CO_N'(CO_NS);
    localparam logic [CO_N-1:0] OP_LP = CO_N'(CO_LP);
    localparam logic [CO_N-1:0] OP_RP = CO_N'(CO_RP);
    localparam logic [CO_N-1:0] OP_OK = CO_N'(CO_OK);

    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_REDUCE, S_FLUSH, S_ERROR} state_t;
    typedef enum logic [2:0] {
        A_NONE, A_PUSH, A_POP_LP, A_REDUCE, A_FLUSH, A_OVERFLOW, A_BAD_RP, A_DISCARD
    } action_t;

    state_t          state;
    action_t         action;
    logic [CO_N-1:0] stack [DEPTH];
    logic [CO_N-1:0] top;
    logic            empty;
    logic            full;
    logic            top_lp;
    logic            lle_rlt;

    assign empty  = depth == '0;
    assign full   = depth == DW'(DEPTH);
    assign top    = stack[AW'(depth - DW'(1))];
    assign top_lp = top == OP_LP;

    precedence #(.CO_N(CO_N)) u_prec (
        .a       (tok_op),
        .b       (top),
        .lle_rlt (lle_rlt)
    );

    // Per-token decision, made in the same cycle the token is presented.
    always_comb begin
        action = A_NONE;
        if (!clear && tok_valid && (state == S_IDLE || state == S_ACCEPT)) begin
            case (tok_op)
                OP_LP, OP_PS, OP_NS: action = full ? A_OVERFLOW : A_PUSH;
                OP_RP: begin
                    if (empty)       action = A_BAD_RP;
                    else if (top_lp) action = A_POP_LP;
                    else             action = A_REDUCE;
                end
                OP_AD, OP_SB, OP_MU, OP_DI: begin
                    if (!empty && !top_lp && lle_rlt) action = A_REDUCE;
                    else                              action = full ? A_OVERFLOW : A_PUSH;
                end
                OP_OK:   action = A_FLUSH;
                default: action = A_DISCARD;
            endcase
        end
    end

    assign tok_ready = (action == A_PUSH) || (action == A_POP_LP) ||
                       (action == A_FLUSH) || (action == A_DISCARD);

    always_ff @(posedge clk) begin
        if (action == A_PUSH) stack[AW'(depth)] <= tok_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            depth    <= '0;
            ev_valid <= 1'b0;
            ev_op    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else if (clear) begin
            state    <= S_IDLE;
            depth    <= '0;
            ev_valid <= 1'b0;
            ev_op    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_ACCEPT: begin
                    if (tok_valid) state <= S_ACCEPT;
                    case (action)
                        A_PUSH:   depth <= depth + DW'(1);
                        A_POP_LP: depth <= depth - DW'(1);
                        A_REDUCE: begin
                            ev_valid <= 1'b1;
                            ev_op    <= top;
                            state    <= S_REDUCE;
                        end
                        A_FLUSH: state <= S_FLUSH;
                        A_OVERFLOW: begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end
                        A_BAD_RP: begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end
                        default: ;
                    endcase
                end
                // The pending token stays on tok_op and is re-judged against the new top.
                S_REDUCE: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        depth    <= depth - DW'(1);
                        state    <= S_ACCEPT;
                    end
                end
                S_FLUSH: begin
                    if (ev_valid) begin
                        if (ev_ready) begin
                            ev_valid <= 1'b0;
                            depth    <= depth - DW'(1);
                        end
                    end else if (empty) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (top_lp) begin
                        state    <= S_ERROR;
                        err      <= 1'b1;
                        err_code <= 2'd3;
                    end else begin
                        ev_valid <= 1'b1;
                        ev_op    <= top;
                    end
                end
                S_ERROR: ;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
